// File: rtl/wb_pkg.sv
// Shared definitions for the writeback arbiter: result payload struct, default
// widths and requester indices.
package wb_pkg;

  localparam int NUM_REQ   = 4;
  localparam int XLEN      = 32;
  localparam int ROB_IDX_W = 3;
  localparam int PREG_W    = 7;

  localparam int WB_SRC_ALU = 0;
  localparam int WB_SRC_MUL = 1;
  localparam int WB_SRC_LSU = 2;
  localparam int WB_SRC_CSR = 3;

  typedef struct packed {
    logic [XLEN-1:0]      data;
    logic [ROB_IDX_W-1:0] rob_idx;
    logic [PREG_W-1:0]    rd;
  } wb_req_t;

  // Width of a requester index; never zero, even for a single requester.
  function automatic int src_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Producer-side and writeback-side signals of the writeback arbiter.
// master = producers/ROB side, slave = the arbiter.
interface wb_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int XLEN      = 32,
  parameter int ROB_IDX_W = 3,
  parameter int PREG_W    = 7
);
  localparam int SRC_W  = wb_pkg::src_w(NUM_REQ);
  localparam int MASK_W = 2 ** ROB_IDX_W;

  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ*XLEN-1:0]      req_data;
  logic [NUM_REQ*ROB_IDX_W-1:0] req_rob_idx;
  logic [NUM_REQ*PREG_W-1:0]    req_rd;
  logic                         mispredict;
  logic [MASK_W-1:0]            flush_mask;
  logic                         writeback_free;
  logic                         WB_out_valid;
  logic [XLEN-1:0]              WB_out_data;
  logic [ROB_IDX_W-1:0]         WB_out_rob_idx;
  logic [PREG_W-1:0]            WB_out_rd;
  logic [SRC_W-1:0]             WB_out_src;

  modport master (
    output req_valid, req_data, req_rob_idx, req_rd,
    output mispredict, flush_mask, writeback_free,
    input  req_ready,
    input  WB_out_valid, WB_out_data, WB_out_rob_idx, WB_out_rd, WB_out_src
  );

  modport slave (
    input  req_valid, req_data, req_rob_idx, req_rd,
    input  mispredict, flush_mask, writeback_free,
    output req_ready,
    output WB_out_valid, WB_out_data, WB_out_rob_idx, WB_out_rd, WB_out_src
  );

endinterface

// File: rtl/rr_arbiter.sv
// One-hot grant selector. WB_ARB_RR_EN defined: round-robin with an internal
// pointer; undefined: fixed priority, lowest index wins.
module rr_arbiter
  import wb_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     eligible,
  input  logic             enable,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W-1:0] ptr;
  logic             found;

`ifdef WB_ARB_RR_EN
  logic [IDX_W-1:0] ptr_q, ptr_d;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking is reserved for combinational temporaries.
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (enable && found) begin
      ptr_d = (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  assign ptr = ptr_q;
`else
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;
  assign ptr = '0;
`endif

  // Search upward from the pointer, wrapping at N; first eligible wins.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    found     = 1'b0;
    grant_idx = '0;
    for (int off = 0; off < N; off++) begin
      int j;
      j = int'(ptr) + off;
      if (j >= N) j = j - N;
      if (!found && eligible[j]) begin
        found     = 1'b1;
        grant_idx = IDX_W'(j);
      end
    end
    grant = (enable && found) ? (N'(1) << grant_idx) : '0;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: grants one producer per cycle into a registered output
// slot, drops mispredict-killed results. Round-robin when WB_ARB_RR_EN is defined.
module wb_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int XLEN      = 32,
  parameter int ROB_IDX_W = 3,
  parameter int PREG_W    = 7
) (
  input  logic         clk,
  input  logic         rst,
  wb_arbiter_if.slave  bus
);

  localparam int SRC_W = wb_pkg::src_w(NUM_REQ);

  logic [NUM_REQ-1:0]   killed;
  logic [NUM_REQ-1:0]   eligible;
  logic [NUM_REQ-1:0]   grant;
  logic [SRC_W-1:0]     grant_idx;
  logic                 slot_killed;
  logic                 load;
  logic                 arb_en;

  logic                 slot_valid_q, slot_valid_d;
  logic [XLEN-1:0]      slot_data_q, slot_data_d;
  logic [ROB_IDX_W-1:0] slot_rob_q, slot_rob_d;
  logic [PREG_W-1:0]    slot_rd_q, slot_rd_d;
  logic [SRC_W-1:0]     slot_src_q, slot_src_d;

  always_comb begin
    killed = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      killed[i] = bus.mispredict &&
                  bus.flush_mask[bus.req_rob_idx[i*ROB_IDX_W +: ROB_IDX_W]];
    end
    // A killed slot frees itself this cycle, so it may be refilled at once.
    slot_killed = bus.mispredict && bus.flush_mask[slot_rob_q];
    load        = !slot_valid_q || bus.writeback_free || slot_killed;
    eligible    = bus.req_valid & ~killed;
    arb_en      = load && !rst;
  end

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (SRC_W)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .eligible  (eligible),
    .enable    (arb_en),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Killed requests are consumed (dropped) regardless of slot state.
  assign bus.req_ready = rst ? '0 : (grant | (bus.req_valid & killed));

  always_comb begin
    slot_valid_d = slot_valid_q;
    slot_data_d  = slot_data_q;
    slot_rob_d   = slot_rob_q;
    slot_rd_d    = slot_rd_q;
    slot_src_d   = slot_src_q;
    if (load) begin
      slot_valid_d = |grant;
      if (|grant) begin
        slot_data_d = bus.req_data[int'(grant_idx)*XLEN +: XLEN];
        slot_rob_d  = bus.req_rob_idx[int'(grant_idx)*ROB_IDX_W +: ROB_IDX_W];
        slot_rd_d   = bus.req_rd[int'(grant_idx)*PREG_W +: PREG_W];
        slot_src_d  = grant_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_valid_q <= 1'b0;
      slot_data_q  <= '0;
      slot_rob_q   <= '0;
      slot_rd_q    <= '0;
      slot_src_q   <= '0;
    end else begin
      slot_valid_q <= slot_valid_d;
      slot_data_q  <= slot_data_d;
      slot_rob_q   <= slot_rob_d;
      slot_rd_q    <= slot_rd_d;
      slot_src_q   <= slot_src_d;
    end
  end

  assign bus.WB_out_valid   = slot_valid_q;
  assign bus.WB_out_data    = slot_data_q;
  assign bus.WB_out_rob_idx = slot_rob_q;
  assign bus.WB_out_rd      = slot_rd_q;
  assign bus.WB_out_src     = slot_src_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter; expectations follow the build
// (WB_ARB_RR_EN defined: round-robin, otherwise fixed priority).
module tb_wb_arbiter;
  import wb_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  wb_arbiter_if #(
    .NUM_REQ(NUM_REQ), .XLEN(XLEN), .ROB_IDX_W(ROB_IDX_W), .PREG_W(PREG_W)
  ) bus ();

  wb_arbiter #(
    .NUM_REQ(NUM_REQ), .XLEN(XLEN), .ROB_IDX_W(ROB_IDX_W), .PREG_W(PREG_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [31:0] d, input logic [2:0] rob,
                         input logic [6:0] rd);
    wb_req_t r;
    r = '{data: d, rob_idx: rob, rd: rd};
    bus.req_data[i*XLEN +: XLEN]               = r.data;
    bus.req_rob_idx[i*ROB_IDX_W +: ROB_IDX_W]  = r.rob_idx;
    bus.req_rd[i*PREG_W +: PREG_W]             = r.rd;
  endtask

  function automatic int contention_src(input int c);
`ifdef WB_ARB_RR_EN
    return c % NUM_REQ;
`else
    return WB_SRC_ALU + 0 * c;
`endif
  endfunction

  function automatic logic [3:0] onehot(input int k);
    logic [3:0] one;
    one = 4'b0001;
    return one << k;
  endfunction

  task automatic check_slot(input string tag, input int src, input logic [31:0] d,
                            input logic [2:0] rob, input logic [6:0] rd);
    check({tag, "_valid"}, 64'(bus.WB_out_valid), 64'd1);
    check({tag, "_src"},   64'(bus.WB_out_src),   64'(src));
    check({tag, "_data"},  64'(bus.WB_out_data),  64'(d));
    check({tag, "_rob"},   64'(bus.WB_out_rob_idx), 64'(rob));
    check({tag, "_rd"},    64'(bus.WB_out_rd),    64'(rd));
  endtask

  initial begin
    rst                = 1'b1;
    bus.req_valid      = 4'b1111;
    bus.mispredict     = 1'b0;
    bus.flush_mask     = '0;
    bus.writeback_free = 1'b1;
    bus.req_data       = '0;
    bus.req_rob_idx    = '0;
    bus.req_rd         = '0;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 32'hA000_0000 + i, 3'(i), 7'(10 + i));

    // Reset held two cycles with every producer requesting.
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      check("rst_valid", 64'(bus.WB_out_valid), 64'd0);
      check("rst_data",  64'(bus.WB_out_data),  64'd0);
      check("rst_rob",   64'(bus.WB_out_rob_idx), 64'd0);
      check("rst_rd",    64'(bus.WB_out_rd),    64'd0);
      check("rst_src",   64'(bus.WB_out_src),   64'd0);
      check("rst_ready", 64'(bus.req_ready),    64'd0);
    end

    // Contention: all four requesting for eight cycles.
    @(negedge clk); rst = 1'b0; #1;
    check("cont_ready0", 64'(bus.req_ready), 64'(onehot(contention_src(0))));
    for (int c = 1; c < 8; c++) begin
      @(negedge clk); #1;
      check_slot("cont_slot", contention_src(c - 1), 32'hA000_0000 + 32'(contention_src(c - 1)),
                 3'(contention_src(c - 1)), 7'(10 + contention_src(c - 1)));
      check("cont_ready", 64'(bus.req_ready), 64'(onehot(contention_src(c))));
    end
    @(negedge clk); bus.req_valid = 4'b0000; #1;
    check("cont_last_src", 64'(bus.WB_out_src), 64'(contention_src(7)));
    check("idle_ready",    64'(bus.req_ready),  64'd0);

    // Backpressure: ALU result held while MUL waits.
    @(negedge clk);
    set_req(WB_SRC_ALU, 32'hDEAD_BEEF, 3'd0, 7'd12);
    bus.req_valid = 4'b0001; #1;
    check("idle_cleared", 64'(bus.WB_out_valid), 64'd0);
    check("alu_ready",    64'(bus.req_ready),    64'b0001);
    @(negedge clk);
    bus.req_valid = 4'b0010; bus.writeback_free = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      check_slot("bp_hold", WB_SRC_ALU, 32'hDEAD_BEEF, 3'd0, 7'd12);
      check("bp_ready", 64'(bus.req_ready), 64'd0);
    end
    @(negedge clk); bus.writeback_free = 1'b1; #1;
    check("bp_release_ready", 64'(bus.req_ready), 64'b0010);
    check("bp_release_data",  64'(bus.WB_out_data), 64'h0000_0000_DEAD_BEEF);
    @(negedge clk); bus.req_valid = 4'b0000; #1;
    check_slot("mul_slot", WB_SRC_MUL, 32'hA000_0001, 3'd1, 7'd11);

    // Flush: MUL (rob 5) killed, LSU (rob 2) survives and is granted.
    @(negedge clk);
    set_req(WB_SRC_MUL, 32'hA000_0001, 3'd5, 7'd11);
    set_req(WB_SRC_LSU, 32'hA000_0002, 3'd2, 7'd12);
    bus.req_valid = 4'b0110; bus.mispredict = 1'b1; bus.flush_mask = 8'b0010_0000; #1;
    check("flush_ready", 64'(bus.req_ready), 64'b0110);
    @(negedge clk); bus.req_valid = 4'b0000; bus.mispredict = 1'b0; bus.flush_mask = '0; #1;
    check_slot("flush_slot", WB_SRC_LSU, 32'hA000_0002, 3'd2, 7'd12);

    // Killed slot: CSR result at rob 6 flushed during hold, ALU refills.
    @(negedge clk);
    set_req(WB_SRC_CSR, 32'hC5C5_0006, 3'd6, 7'd20);
    bus.req_valid = 4'b1000; #1;
    check("csr_ready", 64'(bus.req_ready), 64'b1000);
    @(negedge clk);
    set_req(WB_SRC_ALU, 32'h1111_0001, 3'd1, 7'd21);
    bus.req_valid = 4'b0001; bus.writeback_free = 1'b0;
    bus.mispredict = 1'b1; bus.flush_mask = 8'b0100_0000; #1;
    check_slot("kslot_before", WB_SRC_CSR, 32'hC5C5_0006, 3'd6, 7'd20);
    check("kslot_ready", 64'(bus.req_ready), 64'b0001);
    @(negedge clk); bus.req_valid = 4'b0000; bus.mispredict = 1'b0; bus.flush_mask = '0; #1;
    check_slot("kslot_after", WB_SRC_ALU, 32'h1111_0001, 3'd1, 7'd21);

    // All requesters killed (and the slot too): all ready, no grant.
    @(negedge clk);
    bus.req_valid = 4'b0011; bus.mispredict = 1'b1; bus.flush_mask = 8'b0010_0010; #1;
    check("allkill_ready", 64'(bus.req_ready), 64'b0011);
    @(negedge clk); bus.req_valid = 4'b0000; bus.mispredict = 1'b0; bus.flush_mask = '0; #1;
    check("allkill_empty", 64'(bus.WB_out_valid), 64'd0);

    // Reset mid-operation drops the in-flight slot.
    @(negedge clk); bus.req_valid = 4'b0001; bus.writeback_free = 1'b1; #1;
    check("pre_rst_ready", 64'(bus.req_ready), 64'b0001);
    @(negedge clk); rst = 1'b1; bus.req_valid = 4'b0000; #1;
    check("pre_rst_valid", 64'(bus.WB_out_valid), 64'd1);
    @(negedge clk); bus.req_valid = 4'b0001; #1;
    check("mid_rst_valid", 64'(bus.WB_out_valid), 64'd0);
    check("mid_rst_data",  64'(bus.WB_out_data),  64'd0);
    check("mid_rst_src",   64'(bus.WB_out_src),   64'd0);
    check("mid_rst_ready", 64'(bus.req_ready),    64'd0);
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
